// File: rtl/snake_pkg.sv
// Shared types and constants for the snake collision datapath.
package snake_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    typedef logic [3:0] xcoord_t;
    typedef logic [2:0] ycoord_t;

    localparam int GRID_W   = 16;
    localparam int GRID_H   = 8;
    localparam int INIT_LEN = 3;
    localparam int INIT_HX  = 8;
    localparam int INIT_HY  = 4;

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        logic r;
        r = 1'b0;
        case (a)
            DIR_UP:    r = (b == DIR_DOWN);
            DIR_DOWN:  r = (b == DIR_UP);
            DIR_LEFT:  r = (b == DIR_RIGHT);
            DIR_RIGHT: r = (b == DIR_LEFT);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head step with wall detection; up decrements the row.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 8
) (
    input  xcoord_t head_x,
    input  ycoord_t head_y,
    input  dir_t    dir,
    output xcoord_t nh_x,
    output ycoord_t nh_y,
    output logic    wall_hit
);

    logic signed [4:0] dx, dy, sx, sy;

    always_comb begin
        dx = 5'sd0;
        dy = 5'sd0;
        case (dir)
            DIR_UP:    dy = -5'sd1;
            DIR_DOWN:  dy = 5'sd1;
            DIR_LEFT:  dx = -5'sd1;
            DIR_RIGHT: dx = 5'sd1;
            default: ;
        endcase
        sx = $signed({1'b0, head_x}) + dx;
        sy = $signed({2'b00, head_y}) + dy;
        // Column 15+1 wraps to a negative 5-bit value, so the sign test catches it too.
        wall_hit = (sx < 5'sd0) || (int'(sx) >= GRID_W) ||
                   (sy < 5'sd0) || (int'(sy) >= GRID_H);
        nh_x = sx[3:0];
        nh_y = sy[2:0];
    end

endmodule

// File: rtl/snake_collision_unit.sv
// Snake body store, head advance and wall/body/apple collision pulses.
module snake_collision_unit #(
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = snake_pkg::INIT_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_tick,
    input  logic [3:0] dir_pulse,
    input  logic [3:0] apple_x,
    input  logic [2:0] apple_y,
    output logic       goodColl,
    output logic       badColl,
    output logic [3:0] head_x,
    output logic [2:0] head_y,
    output logic [6:0] length,
    input  logic [5:0] rd_idx,
    output logic [3:0] rd_x,
    output logic [2:0] rd_y,
    output logic       rd_valid,
    output logic       alive
);
    import snake_pkg::*;

    localparam logic [6:0] MAX_LEN_L  = 7'(MAX_LEN);
    localparam logic [6:0] INIT_LEN_L = 7'(INIT_LEN);

    state_t  state;
    dir_t    cur_dir, pend_dir, dir_req;
    logic    dir_ok, wall_hit, body_hit, apple_hit;
    xcoord_t seg_x [MAX_LEN];
    ycoord_t seg_y [MAX_LEN];
    xcoord_t nh_x;
    ycoord_t nh_y;

    function automatic xcoord_t init_x(input int i);
        return (i < INIT_LEN) ? xcoord_t'(INIT_HX - i) : '0;
    endfunction

    function automatic ycoord_t init_y(input int i);
        return (i < INIT_LEN) ? ycoord_t'(INIT_HY) : '0;
    endfunction

    always_comb begin
        dir_ok  = 1'b1;
        dir_req = DIR_RIGHT;
        case (dir_pulse)
            4'b1000: dir_req = DIR_UP;
            4'b0100: dir_req = DIR_DOWN;
            4'b0010: dir_req = DIR_LEFT;
            4'b0001: dir_req = DIR_RIGHT;
            default: dir_ok  = 1'b0;
        endcase
    end

    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
        .head_x   (seg_x[0]),
        .head_y   (seg_y[0]),
        .dir      (pend_dir),
        .nh_x     (nh_x),
        .nh_y     (nh_y),
        .wall_hit (wall_hit)
    );

    assign apple_hit = (nh_x == apple_x) && (nh_y == apple_y);

    // The tail cell vacates this tick unless the apple keeps it in place.
    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (((7'(i) < length - 7'd1) || ((7'(i) == length - 7'd1) && apple_hit)) &&
                (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                body_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            alive    <= 1'b0;
            length   <= INIT_LEN_L;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
        end else begin
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            if (start && state != RUN) begin
                state    <= RUN;
                alive    <= 1'b1;
                length   <= INIT_LEN_L;
                cur_dir  <= DIR_RIGHT;
                pend_dir <= DIR_RIGHT;
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= init_x(i);
                    seg_y[i] <= init_y(i);
                end
            end else begin
                if (dir_ok && !is_opposite(dir_req, cur_dir))
                    pend_dir <= dir_req;
                if (move_tick && state == RUN) begin
                    cur_dir <= pend_dir;
                    if (wall_hit || body_hit) begin
                        badColl <= 1'b1;
                        state   <= DEAD;
                        alive   <= 1'b0;
                    end else begin
                        goodColl <= apple_hit;
                        seg_x[0] <= nh_x;
                        seg_y[0] <= nh_y;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        if (apple_hit && length < MAX_LEN_L)
                            length <= length + 7'd1;
                    end
                end
            end
        end
    end

    assign head_x   = seg_x[0];
    assign head_y   = seg_y[0];
    assign rd_valid = ({1'b0, rd_idx} < length);
    assign rd_x     = rd_valid ? seg_x[rd_idx] : '0;
    assign rd_y     = rd_valid ? seg_y[rd_idx] : '0;

endmodule
